// File: rtl/aes_blok_toplayici_pkg.sv
// Shared types and constants for the AES block assembler.
// The DOLGU state only exists when AES_PADDING_EN is defined.
package aes_blok_toplayici_pkg;

  localparam int BLOK_W      = 128;
  localparam int BAYT_W      = 8;
  localparam int BAYT_SAYISI = 16;
  localparam int SAYAC_W     = 4;

  localparam logic [BAYT_W-1:0] PAD_TAM = 8'h10;

`ifdef AES_PADDING_EN
  typedef enum logic [1:0] {
    TOPLA = 2'd0,
    DOLU  = 2'd1,
    DOLGU = 2'd2
  } durum_t;
`else
  typedef enum logic [1:0] {
    TOPLA = 2'd0,
    DOLU  = 2'd1
  } durum_t;
`endif

endpackage

// File: rtl/aes_blok_toplayici_kaydirici.sv
// Byte shift register with a 4-bit fill counter: byte 0 ends up in the top byte
// after 16 shifts, and the counter wraps back to 0 on the 16th shift.
module blok_kaydirici
  import aes_blok_toplayici_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               kaydir,
  input  logic [BAYT_W-1:0]  veri,
  output logic [BLOK_W-1:0]  blok,
  output logic [SAYAC_W-1:0] sayac
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blok  <= '0;
      sayac <= '0;
    end else if (kaydir) begin
      blok  <= {blok[BLOK_W-BAYT_W-1:0], veri};
      sayac <= sayac + 4'd1;
    end
  end

endmodule

// File: rtl/aes_blok_toplayici.sv
// Collects bytes into 128-bit AES blocks and holds the AES key register.
// Optional PKCS#7 padding on the son byte is enabled by AES_PADDING_EN.
module aes_blok_toplayici
  import aes_blok_toplayici_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [BAYT_W-1:0]  bayt,
  input  logic               bayt_gecerli,
  output logic               bayt_hazir,
  input  logic               son,
  input  logic [BLOK_W-1:0]  anahtar_giris,
  input  logic               anahtar_yaz,
  output logic [BLOK_W-1:0]  anahtar,
  output logic               anahtar_hata,
  output logic [BLOK_W-1:0]  blok,
  output logic               g_gecerli,
  input  logic               hazir,
  output durum_t             durum,
  output logic [SAYAC_W-1:0] sayac
);

  // Handshakes: a byte moves when bayt_gecerli & bayt_hazir, a block moves when
  // g_gecerli & hazir; a raised valid and its data stay put until the transfer.
  durum_t            durum_n;
  logic              kaydir;
  logic [BAYT_W-1:0] kaydir_veri;

  blok_kaydirici u_kaydirici (
    .clk    (clk),
    .rst    (rst),
    .kaydir (kaydir),
    .veri   (kaydir_veri),
    .blok   (blok),
    .sayac  (sayac)
  );

`ifdef AES_PADDING_EN
  logic [BAYT_W-1:0] pad_deger;
  logic              pad_bekliyor;

  // son on the 16th byte leaves a whole 0x10 block queued behind the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_deger    <= '0;
      pad_bekliyor <= 1'b0;
    end else if (durum == TOPLA && bayt_gecerli && son) begin
      pad_deger    <= (sayac == 4'd15) ? PAD_TAM : {4'd0, 4'd15 - sayac};
      pad_bekliyor <= (sayac == 4'd15);
    end else if (durum == DOLU && hazir && pad_bekliyor) begin
      pad_bekliyor <= 1'b0;
    end
  end
`else
  logic son_unused;
  assign son_unused = son;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) durum <= TOPLA;
    else     durum <= durum_n;
  end

  always_comb begin
    durum_n     = durum;
    bayt_hazir  = 1'b0;
    g_gecerli   = 1'b0;
    kaydir      = 1'b0;
    kaydir_veri = bayt;
    case (durum)
      TOPLA: begin
        bayt_hazir = 1'b1;
        if (bayt_gecerli) begin
          kaydir = 1'b1;
          if (sayac == 4'd15) durum_n = DOLU;
`ifdef AES_PADDING_EN
          else if (son) durum_n = DOLGU;
`endif
        end
      end
      DOLU: begin
        g_gecerli = 1'b1;
        if (hazir) begin
`ifdef AES_PADDING_EN
          durum_n = pad_bekliyor ? DOLGU : TOPLA;
`else
          durum_n = TOPLA;
`endif
        end
      end
`ifdef AES_PADDING_EN
      DOLGU: begin
        kaydir      = 1'b1;
        kaydir_veri = pad_deger;
        if (sayac == 4'd15) durum_n = DOLU;
      end
`endif
      default: durum_n = TOPLA;
    endcase
  end

  // The key may only change between messages: idle assembler, empty counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anahtar      <= '0;
      anahtar_hata <= 1'b0;
    end else begin
      anahtar_hata <= 1'b0;
      if (anahtar_yaz) begin
        if (durum == TOPLA && sayac == 4'd0) anahtar <= anahtar_giris;
        else                                 anahtar_hata <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_blok_toplayici.sv
// Directed bench for aes_blok_toplayici; padding checks run when AES_PADDING_EN is defined.
module tb_aes_blok_toplayici;
  import aes_blok_toplayici_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   bayt;
  logic         bayt_gecerli;
  logic         bayt_hazir;
  logic         son;
  logic [127:0] anahtar_giris;
  logic         anahtar_yaz;
  logic [127:0] anahtar;
  logic         anahtar_hata;
  logic [127:0] blok;
  logic         g_gecerli;
  logic         hazir;
  durum_t       durum;
  logic [3:0]   sayac;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ANAHTAR_1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ANAHTAR_2 = 128'hffeeddccbbaa99887766554433221100;

  aes_blok_toplayici dut (
    .clk           (clk),
    .rst           (rst),
    .bayt          (bayt),
    .bayt_gecerli  (bayt_gecerli),
    .bayt_hazir    (bayt_hazir),
    .son           (son),
    .anahtar_giris (anahtar_giris),
    .anahtar_yaz   (anahtar_yaz),
    .anahtar       (anahtar),
    .anahtar_hata  (anahtar_hata),
    .blok          (blok),
    .g_gecerli     (g_gecerli),
    .hazir         (hazir),
    .durum         (durum),
    .sayac         (sayac)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s);
    bayt         = b;
    son          = s;
    bayt_gecerli = 1'b1;
    tick();
    bayt_gecerli = 1'b0;
    son          = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (g_gecerli !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {127'd0, g_gecerli}, 128'd1);
  endtask

  initial begin
    rst = 1'b1; bayt = '0; bayt_gecerli = 1'b0; son = 1'b0;
    anahtar_giris = '0; anahtar_yaz = 1'b0; hazir = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_g_gecerli", {127'd0, g_gecerli}, 128'd0);
    chk("rst_blok", blok, 128'd0);
    chk("rst_anahtar", anahtar, 128'd0);
    chk("rst_hata", {127'd0, anahtar_hata}, 128'd0);
    rst = 1'b0;
    tick();
    chk("rst_bayt_hazir", {127'd0, bayt_hazir}, 128'd1);
    chk("rst_sayac", {124'd0, sayac}, 128'd0);

    // Stream 00,11,..,ff; key write together with byte 0, rejected write at counter 5.
    anahtar_giris = ANAHTAR_1;
    anahtar_yaz   = 1'b1;
    send_byte(8'h00, 1'b0);
    anahtar_yaz   = 1'b0;
    chk("key_ok", anahtar, ANAHTAR_1);
    chk("key_ok_hata", {127'd0, anahtar_hata}, 128'd0);
    chk("key_byte_sayac", {124'd0, sayac}, 128'd1);
    for (int i = 1; i < 5; i++) send_byte(8'(i * 8'h11), 1'b0);
    chk("sayac5", {124'd0, sayac}, 128'd5);
    anahtar_giris = ANAHTAR_2;
    anahtar_yaz   = 1'b1;
    tick();
    anahtar_yaz   = 1'b0;
    chk("key_rej", anahtar, ANAHTAR_1);
    chk("key_rej_hata", {127'd0, anahtar_hata}, 128'd1);
    tick();
    chk("key_rej_hata_pulse", {127'd0, anahtar_hata}, 128'd0);
    for (int i = 5; i < 15; i++) begin
      send_byte(8'(i * 8'h11), 1'b0);
      chk("no_early_valid", {127'd0, g_gecerli}, 128'd0);
    end
    send_byte(8'hff, 1'b0);
    chk("blk1_valid", {127'd0, g_gecerli}, 128'd1);
    chk("blk1_data", blok, 128'h00112233445566778899aabbccddeeff);
    chk("blk1_no_bypass", {127'd0, bayt_hazir}, 128'd0);
    chk("blk1_sayac_wrap", {124'd0, sayac}, 128'd0);
    tick();
    chk("blk1_single_pulse", {127'd0, g_gecerli}, 128'd0);
    chk("blk1_hazir_back", {127'd0, bayt_hazir}, 128'd1);

    // Backpressure: hold hazir low for 10 cycles in DOLU.
    hazir = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'hf0 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {127'd0, g_gecerli}, 128'd1);
      chk("bp_data", blok, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
      chk("bp_bayt_hazir", {127'd0, bayt_hazir}, 128'd0);
      if (i == 3) anahtar_yaz = 1'b1;
      tick();
      if (i == 3) begin
        anahtar_yaz = 1'b0;
        chk("key_in_dolu_hata", {127'd0, anahtar_hata}, 128'd1);
        chk("key_in_dolu_keep", anahtar, ANAHTAR_1);
      end
    end
    hazir = 1'b1;
    tick();
    chk("bp_done_valid", {127'd0, g_gecerli}, 128'd0);
    chk("bp_done_bayt_hazir", {127'd0, bayt_hazir}, 128'd1);

    // Asynchronous reset after 7 bytes discards the partial block.
    for (int i = 0; i < 7; i++) send_byte(8'(8'h50 + i), 1'b0);
    rst = 1'b1;
    #2;
    chk("mid_rst_sayac", {124'd0, sayac}, 128'd0);
    chk("mid_rst_blok", blok, 128'd0);
    chk("mid_rst_anahtar", anahtar, 128'd0);
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", {127'd0, g_gecerli}, 128'd0);
    hazir = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'ha0 + i), 1'b0);
    chk("post_rst_valid", {127'd0, g_gecerli}, 128'd1);
    chk("post_rst_data", blok, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);

    // Reset while DOLU drops the pending block.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dolu_rst_no_valid", {127'd0, g_gecerli}, 128'd0);
    end
    chk("dolu_rst_bayt_hazir", {127'd0, bayt_hazir}, 128'd1);

`ifdef AES_PADDING_EN
    for (int i = 1; i <= 13; i++) send_byte(8'(i), (i == 13));
    chk("pad_dolgu_bayt_hazir", {127'd0, bayt_hazir}, 128'd0);
    wait_valid("pad_wait");
    chk("pad_data", blok, 128'h0102030405060708090a0b0c0d030303);
    hazir = 1'b1;
    tick();
    hazir = 1'b0;
    chk("pad_back_topla", {127'd0, bayt_hazir}, 128'd1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), (i == 15));
    chk("full_valid", {127'd0, g_gecerli}, 128'd1);
    chk("full_data", blok, 128'h202122232425262728292a2b2c2d2e2f);
    hazir = 1'b1;
    tick();
    hazir = 1'b0;
    chk("full_pad_bayt_hazir", {127'd0, bayt_hazir}, 128'd0);
    wait_valid("full_pad_wait");
    chk("full_pad_data", blok, {16{8'h10}});
    hazir = 1'b1;
    tick();
    chk("full_pad_done", {127'd0, g_gecerli}, 128'd0);
    chk("full_pad_topla", {127'd0, bayt_hazir}, 128'd1);
`else
    for (int i = 1; i <= 13; i++) send_byte(8'(i), (i == 13));
    chk("son_ignored_hazir", {127'd0, bayt_hazir}, 128'd1);
    chk("son_ignored_sayac", {124'd0, sayac}, 128'd13);
    chk("son_ignored_valid", {127'd0, g_gecerli}, 128'd0);
    for (int i = 14; i <= 16; i++) send_byte(8'(i), 1'b0);
    chk("son_ignored_blk_valid", {127'd0, g_gecerli}, 128'd1);
    chk("son_ignored_blk_data", blok, 128'h0102030405060708090a0b0c0d0e0f10);
    hazir = 1'b1;
    tick();
    chk("son_ignored_done", {127'd0, g_gecerli}, 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_blok_toplayici.md
AES_BLOK_TOPLAYICI -- requirements
Module: aes_blok_toplayici

Interface
REQ-001 SHALL have these ports: clk, in, 1, system clock; all logic is on the rising edge.
REQ-002 SHALL have: rst, in, 1, asynchronous active-high reset.
REQ-003 SHALL have: bayt, in, 8, upstream data byte.
REQ-004 SHALL have: bayt_gecerli, in, 1, bayt is valid.
REQ-005 SHALL have: bayt_hazir, out, 1, block accepts a byte.
REQ-006 SHALL have: son, in, 1, qualifies the last byte of a message.
REQ-007 SHALL have: anahtar_giris, in, 128, new key value.
REQ-008 SHALL have: anahtar_yaz, in, 1, key write strobe.
REQ-009 SHALL have: anahtar, out, 128, registered key driven to the AES engine.
REQ-010 SHALL have: anahtar_hata, out, 1, one-cycle pulse when a key write is rejected.
REQ-011 SHALL have: blok, out, 128, assembled plaintext block.
REQ-012 SHALL have: g_gecerli, out, 1, blok is valid.
REQ-013 SHALL have: hazir, in, 1, the engine accepts a block.

Function
REQ-014 SHALL assemble 16 bytes, MSB first: byte 0 goes to blok[127:120] and byte 15 to blok[7:0].
REQ-015 SHALL accept a byte on bayt_gecerli & bayt_hazir, and SHALL transfer a block on g_gecerli & hazir.
REQ-016 SHALL implement the FSM states TOPLA, DOLU and DOLGU, and only those states.
REQ-017 SHALL hold bayt_hazir=1 only in TOPLA, and g_gecerli=1 only in DOLU.
REQ-018 In TOPLA, a byte accept with a 4-bit counter value of 15 SHALL wrap the counter to 0 and go to DOLU on the next cycle.
REQ-019 In DOLU, blok and g_gecerli SHALL hold stable until transfer; on transfer the FSM SHALL go to TOPLA, or to DOLGU when a pad is pending.
REQ-020 Block latency SHALL be one cycle: g_gecerli rises on the cycle after the 16th byte is accepted.
REQ-021 There SHALL be no bypass: while in DOLU, bayt_hazir=0.
REQ-022 A key write SHALL update anahtar only when state==TOPLA and counter==0.
REQ-023 Any other key write SHALL leave anahtar unchanged and pulse anahtar_hata for one cycle.
REQ-024 Once set, anahtar SHALL be held until the next successful key write.
REQ-025 A byte accept and a key write in the same cycle at counter 0 SHALL both take effect.

Reset
REQ-026 On rst SHALL asynchronously set: FSM=TOPLA, counter=0, blok=0, anahtar=0, g_gecerli=0, anahtar_hata=0, pad state cleared.
REQ-027 On reset deassertion, bayt_hazir SHALL be 1.
REQ-028 Reset mid-block SHALL discard the partial block, and reset in DOLU SHALL drop the pending block, with no g_gecerli afterwards.

Configuration
REQ-029 With AES_PADDING_EN defined, accepting a byte with son=1 SHALL apply PKCS#7 padding.
REQ-030 Let k be the bytes filled including the son byte; for k<16 the FSM SHALL enter DOLGU and insert pad byte (16-k), one per cycle, into the remaining 16-k positions, then go to DOLU.
REQ-031 For k=16, after that block transfers, DOLGU SHALL generate a full block of 0x10 bytes.
REQ-032 In DOLGU, bayt_hazir SHALL be 0.
REQ-033 Without AES_PADDING_EN, son SHALL be ignored, the DOLGU state SHALL not exist, and a partial block SHALL wait for more bytes.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, BLOK_W=128, BAYT_W=8, BAYT_SAYISI=16 and the pad value 0x10.
REQ-035 The byte-shift register with counter SHALL be one sub-module, blok_kaydirici, and the FSM, key register and padding SHALL live in the top module.

Verification
REQ-036 Bytes 0x00,0x11,...,0xff streamed with hazir=1 SHALL give blok=00112233445566778899aabbccddeeff and a single g_gecerli pulse one cycle after the 16th byte.
REQ-037 With hazir held 0 for 10 cycles after DOLU, g_gecerli and blok SHALL stay stable and bayt_hazir SHALL stay 0; on hazir=1 the transfer SHALL complete and bayt_hazir=1 on the next cycle.
REQ-038 A key write at counter 0 with anahtar_giris=000102030405060708090a0b0c0d0e0f SHALL update anahtar; a key write at counter 5 SHALL leave anahtar unchanged and pulse anahtar_hata once.
REQ-039 With AES_PADDING_EN, 13 bytes with son on the 13th SHALL give bytes 13-15 equal to 0x03; 16 bytes with son on the 16th SHALL give two blocks, the second all 0x10.
REQ-040 Asserting rst after 7 bytes SHALL give counter=0 and no g_gecerli; the next 16 bytes SHALL form a correct block.
